// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch (IF)
// and the load/store unit (LS). Each transfer takes one arbitration edge plus
// WAIT_CYCLES access cycles; LS has priority over IF.
// Optional feature macro: ARB_STARVE_GUARD_EN -- when defined, a streak counter
// bounds how many LS grants in a row may be made while fetch is waiting.
//
//   state  | meaning
//   IDLE   | no access in flight, arbitrate on every edge
//   ACCESS | memory enabled for WAIT_CYCLES cycles, cnt counts down to 0
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int WAIT_CYCLES   = 1,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sel_if;
  logic             pick_if;

  // Reject parameter values the access sequencing cannot support.
  if (WAIT_CYCLES < 1 || MAX_LS_STREAK < 1) begin : g_param_check
    $error("mem_port_arbiter: WAIT_CYCLES and MAX_LS_STREAK must be >= 1");
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_LS_STREAK + 1);

  logic [SW-1:0] streak;

  // IF wins when LS is idle, or when LS has already won MAX_LS_STREAK times in a row.
  always_comb begin
    pick_if = if_req && (!ls_req || (streak == SW'(MAX_LS_STREAK)));
  end

  // Count LS grants that made fetch wait; any grant that did not starve IF restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (state == IDLE && (if_req || ls_req)) begin
      if (pick_if || !if_req) begin
        streak <= '0;
      end else begin
        streak <= streak + 1'b1;
      end
    end
  end
`else
  // Strict priority: fetch only wins when load/store is not requesting.
  always_comb begin
    pick_if = !ls_req;
  end
`endif

  // Arbitration, access sequencing and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_if    <= 1'b0;
      if_gnt    <= 1'b0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      ls_gnt    <= 1'b0;
      ls_rdata  <= '0;
      ls_valid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      if_gnt   <= 1'b0;
      ls_gnt   <= 1'b0;
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            state     <= ACCESS;
            cnt       <= CNT_W'(WAIT_CYCLES - 1);
            sel_if    <= pick_if;
            if_gnt    <= pick_if;
            ls_gnt    <= !pick_if;
            mem_en    <= 1'b1;
            mem_we    <= !pick_if && ls_we;
            mem_addr  <= pick_if ? if_addr : ls_addr;
            mem_wdata <= pick_if ? '0 : ls_wdata;
            busy      <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            busy   <= 1'b0;
            if (sel_if) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              ls_valid <= 1'b1;
              // Stores only acknowledge; the last load data stays visible.
              if (!mem_we) begin
                ls_rdata <= mem_rdata;
              end
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: one instance with WAIT_CYCLES=1 and one with
// WAIT_CYCLES=3, both driven by the same request inputs, each with its own memory.
// Expectations for the fetch-starvation order follow ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;

  logic        a_if_gnt, a_if_valid, a_ls_gnt, a_ls_valid, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_if_rdata, a_ls_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_if_gnt, b_if_valid, b_ls_gnt, b_ls_valid, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1), .MAX_LS_STREAK(4)) u_a (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rdata(a_if_rdata),
    .if_valid(a_if_valid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(a_ls_gnt), .ls_rdata(a_ls_rdata), .ls_valid(a_ls_valid),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3), .MAX_LS_STREAK(4)) u_b (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rdata(b_if_rdata),
    .if_valid(b_if_valid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(b_ls_gnt), .ls_rdata(b_ls_rdata), .ls_valid(b_ls_valid),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory models: fixed preload pattern, overridden by any word written since time 0.
  function automatic logic [31:0] rom(input logic [31:0] addr);
    case (addr)
      32'h0000_0010: rom = 32'h00A0_0093;
      32'h0000_0014: rom = 32'h1234_5678;
      32'h0000_0300: rom = 32'h0BAD_CAFE;
      default:       rom = addr ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  bit          a_wv [256];
  logic [31:0] a_wm [256];
  bit          b_wv [256];
  logic [31:0] b_wm [256];

  always_comb a_mem_rdata = a_wv[a_mem_addr[9:2]] ? a_wm[a_mem_addr[9:2]] : rom(a_mem_addr);
  always_comb b_mem_rdata = b_wv[b_mem_addr[9:2]] ? b_wm[b_mem_addr[9:2]] : rom(b_mem_addr);

  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) begin
      a_wv[a_mem_addr[9:2]] <= 1'b1;
      a_wm[a_mem_addr[9:2]] <= a_mem_wdata;
    end
    if (b_mem_en && b_mem_we) begin
      b_wv[b_mem_addr[9:2]] <= 1'b1;
      b_wm[b_mem_addr[9:2]] <= b_mem_wdata;
    end
  end

  // The two ports must never see grant or valid together.
  always @(negedge clk) begin
    if (!reset) begin
      n_chk++;
      if ((a_if_gnt && a_ls_gnt) || (a_if_valid && a_ls_valid) ||
          (b_if_gnt && b_ls_gnt) || (b_if_valid && b_ls_valid)) begin
        n_fail++;
        $display("FAIL exclusive: both ports high at %0t (a gnt %b%b val %b%b, b gnt %b%b val %b%b), required never",
                 $time, a_if_gnt, a_ls_gnt, a_if_valid, a_ls_valid,
                 b_if_gnt, b_ls_gnt, b_if_valid, b_ls_valid);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] last_if;

  // One complete transfer on the WAIT_CYCLES=1 instance, starting from IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    if_req   = v.is_if;
    ls_req   = !v.is_if;
    if_addr  = v.addr;
    ls_addr  = v.addr;
    ls_we    = v.we;
    ls_wdata = v.wdata;
    tick();
    chk($sformatf("v%0d gnt", idx), 32'({a_if_gnt, a_ls_gnt}), v.is_if ? 32'd2 : 32'd1);
    chk($sformatf("v%0d mem_en", idx), 32'(a_mem_en), 32'd1);
    chk($sformatf("v%0d mem_we", idx), 32'(a_mem_we), 32'(v.we && !v.is_if));
    chk($sformatf("v%0d mem_addr", idx), a_mem_addr, v.addr);
    if (v.we && !v.is_if) chk($sformatf("v%0d mem_wdata", idx), a_mem_wdata, v.wdata);
    chk($sformatf("v%0d busy", idx), 32'(a_busy), 32'd1);
    if_req = 1'b0;
    ls_req = 1'b0;
    tick();
    chk($sformatf("v%0d valid", idx), 32'({a_if_valid, a_ls_valid}), v.is_if ? 32'd2 : 32'd1);
    chk($sformatf("v%0d gnt_low", idx), 32'({a_if_gnt, a_ls_gnt}), 32'd0);
    chk($sformatf("v%0d mem_en_off", idx), 32'(a_mem_en), 32'd0);
    chk($sformatf("v%0d busy_off", idx), 32'(a_busy), 32'd0);
    if (v.is_if) begin
      chk($sformatf("v%0d if_rdata", idx), a_if_rdata, v.exp_rdata);
      last_if = v.exp_rdata;
    end else begin
      chk($sformatf("v%0d ls_rdata", idx), a_ls_rdata, v.exp_rdata);
      chk($sformatf("v%0d if_rdata_hold", idx), a_if_rdata, last_if);
    end
  endtask

  task automatic check_b_zero(input string tag);
    chk({tag, " b_busy"}, 32'(b_busy), 32'd0);
    chk({tag, " b_mem_en"}, 32'(b_mem_en), 32'd0);
    chk({tag, " b_mem_addr"}, b_mem_addr, 32'd0);
    chk({tag, " b_gnt"}, 32'({b_if_gnt, b_ls_gnt}), 32'd0);
    chk({tag, " b_valid"}, 32'({b_if_valid, b_ls_valid}), 32'd0);
    chk({tag, " b_ls_rdata"}, b_ls_rdata, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'h00A0_0093};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,          32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,          32'h1234_5678};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0204, 32'h0,          32'hCAFE_F00D};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,          32'hDEAD_BEEF};
    last_if = 32'h0;

    reset = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_addr = '0; ls_wdata = '0;
    tick();
    tick();
    chk("rst a_busy", 32'(a_busy), 32'd0);
    chk("rst a_mem_en", 32'(a_mem_en), 32'd0);
    chk("rst a_outs", 32'({a_if_gnt, a_ls_gnt, a_if_valid, a_ls_valid, a_mem_we}), 32'd0);
    chk("rst a_if_rdata", a_if_rdata, 32'd0);
    chk("rst a_ls_rdata", a_ls_rdata, 32'd0);
    chk("rst a_mem_wdata", a_mem_wdata, 32'd0);
    check_b_zero("rst");
    reset = 1'b0;
    tick();

    // Table-driven single transfers on the WAIT_CYCLES=1 instance.
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Simultaneous requests: LS first, IF only after ls_valid.
    if_req = 1'b1; if_addr = 32'h10;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h204;
    tick();
    chk("both ls_gnt", 32'({a_if_gnt, a_ls_gnt}), 32'd1);
    ls_req = 1'b0;
    tick();
    chk("both ls_valid", 32'({a_if_valid, a_ls_valid, a_if_gnt}), 32'b010);
    chk("both ls_rdata", a_ls_rdata, 32'hCAFE_F00D);
    tick();
    chk("both if_gnt", 32'({a_if_gnt, a_ls_gnt}), 32'd2);
    if_req = 1'b0;
    tick();
    chk("both if_valid", 32'({a_if_valid, a_ls_valid}), 32'd2);
    chk("both if_rdata", a_if_rdata, 32'h00A0_0093);

    // Both held high for 12 grants: grant order depends on the starvation guard.
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h204; if_addr = 32'h10;
    for (int i = 0; i < 12; i++) begin
      int  w;
      logic exp_if;
      w = 0;
      do begin
        tick();
        w++;
      end while (!(a_if_gnt || a_ls_gnt) && w < 6);
`ifdef ARB_STARVE_GUARD_EN
      exp_if = (i % 5 == 4);
`else
      exp_if = 1'b0;
`endif
      if (!(a_if_gnt || a_ls_gnt)) begin
        chk($sformatf("streak%0d timeout", i), 32'd0, 32'd1);
      end else begin
        chk($sformatf("streak%0d if_gnt", i), 32'({a_if_gnt, a_ls_gnt}), exp_if ? 32'd2 : 32'd1);
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    tick(); tick(); tick();

    // WAIT_CYCLES=3 load timing.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300;
    tick();
    chk("w3 c1 gnt", 32'({b_ls_gnt, b_mem_en, b_ls_valid}), 32'b110);
    chk("w3 c1 addr", b_mem_addr, 32'h300);
    ls_req = 1'b0;
    tick();
    chk("w3 c2", 32'({b_ls_gnt, b_mem_en, b_ls_valid}), 32'b010);
    tick();
    chk("w3 c3", 32'({b_ls_gnt, b_mem_en, b_ls_valid}), 32'b010);
    tick();
    chk("w3 valid", 32'({b_ls_gnt, b_mem_en, b_ls_valid, b_busy}), 32'b0010);
    chk("w3 ls_rdata", b_ls_rdata, 32'h0BAD_CAFE);
    tick();
    chk("w3 valid_pulse", 32'(b_ls_valid), 32'd0);

    // Reset during cycle 2 of a WAIT_CYCLES=3 access aborts it.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ls_req = 1'b1; ls_addr = 32'h300;
    tick();
    ls_req = 1'b0;
    chk("abort c1", 32'({b_ls_gnt, b_mem_en}), 32'b11);
    tick();
    chk("abort c2", 32'({b_mem_en, b_busy}), 32'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_b_zero("abort");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("abort no_valid%0d", i), 32'({b_ls_valid, b_mem_en, b_busy}), 32'd0);
    end
    ls_req = 1'b1;
    tick();
    ls_req = 1'b0;
    chk("fresh gnt", 32'(b_ls_gnt), 32'd1);
    tick(); tick(); tick();
    chk("fresh valid", 32'(b_ls_valid), 32'd1);
    chk("fresh ls_rdata", b_ls_rdata, 32'h0BAD_CAFE);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
